// File: rtl/uart_tx_framed.sv
// UART transmitter with configurable frame (5-9 data bits, none/odd/even parity,
// 1-2 stop bits) fed by a small valid/ready FIFO; bit timing from an oversample tick.
module uart_tx_framed #(
  parameter int SAMPLE_RATE = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          tick_in,
  input  logic [DATA_BITS-1:0]          data_in,
  input  logic                          valid_in,
  output logic                          ready_out,
  output logic                          tx_out,
  output logic                          busy_out,
  output logic [$clog2(FIFO_DEPTH):0]   count_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(SAMPLE_RATE);
  localparam int BW = 4;

  localparam logic [CW-1:0] CNT_EMPTY = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_RATE - 1);
  localparam logic [TW-1:0] TICK_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] TICK_ONE  = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0] BIT_ZERO  = 4'd0;
  localparam logic [BW-1:0] BIT_ONE   = 4'd1;
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Odd parity makes the total count of ones (data + parity) odd.
  function automatic logic frame_parity(input logic [DATA_BITS-1:0] d);
    if (PARITY == 1) begin
      return ~(^d);
    end else begin
      return ^d;
    end
  endfunction

  logic [DATA_BITS-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_r;
  logic [PW-1:0]        rd_ptr_r;
  logic [CW-1:0]        count_r;
  logic [CW-1:0]        count_next_s;
  logic                 ready_r;
  logic                 push_s;
  logic                 pop_s;

  state_t               state_r;
  state_t               state_next_s;
  logic [TW-1:0]        tick_cnt_r;
  logic [BW-1:0]        bit_idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_next_s;
  logic                 par_r;
  logic                 par_next_s;
  logic                 tick_end_s;
  logic                 tx_r;
  logic                 tx_next_s;
  logic                 busy_r;
  logic                 busy_next_s;

  assign push_s     = valid_in && ready_r;
  assign tick_end_s = tick_in && (tick_cnt_r == TICK_LAST);

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage; data is captured only at push.
  always_ff @(posedge clk_in) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= data_in;
    end
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= CNT_EMPTY;
      ready_r  <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
      ready_r <= (count_next_s != CNT_FULL);
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state; a pop at end of STOP chains frames with no idle gap.
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (count_r != CNT_EMPTY) begin
          pop_s        = 1'b1;
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_end_s) begin
          state_next_s = ST_DATA;
        end else begin
          state_next_s = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_end_s && (bit_idx_r == LAST_DATA)) begin
          state_next_s = (PARITY != 0) ? ST_PARITY : ST_STOP;
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (tick_end_s) begin
          state_next_s = ST_STOP;
        end else begin
          state_next_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (tick_end_s && (bit_idx_r == LAST_STOP)) begin
          if (count_r != CNT_EMPTY) begin
            pop_s        = 1'b1;
            state_next_s = ST_START;
          end else begin
            state_next_s = ST_IDLE;
          end
        end else begin
          state_next_s = ST_STOP;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Outputs computed from next state so tx_out/busy_out come straight off flops.
  always_comb begin
    shift_next_s = shift_r;
    par_next_s   = par_r;
    tx_next_s    = 1'b1;
    if (pop_s) begin
      shift_next_s = fifo_mem_r[rd_ptr_r];
      par_next_s   = frame_parity(fifo_mem_r[rd_ptr_r]);
    end else if (tick_end_s && (state_r == ST_DATA)) begin
      shift_next_s = {1'b0, shift_r[DATA_BITS-1:1]};
    end else begin
      shift_next_s = shift_r;
    end
    case (state_next_s)
      ST_IDLE:   tx_next_s = 1'b1;
      ST_START:  tx_next_s = 1'b0;
      ST_DATA:   tx_next_s = shift_next_s[0];
      ST_PARITY: tx_next_s = par_next_s;
      ST_STOP:   tx_next_s = 1'b1;
      default:   tx_next_s = 1'b1;
    endcase
    busy_next_s = (state_next_s != ST_IDLE) || (count_next_s != CNT_EMPTY);
  end

  // Bit timing counters, shift register and registered line outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tick_cnt_r <= TICK_ZERO;
      bit_idx_r  <= BIT_ZERO;
      shift_r    <= {DATA_BITS{1'b0}};
      par_r      <= 1'b0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      shift_r <= shift_next_s;
      par_r   <= par_next_s;
      tx_r    <= tx_next_s;
      busy_r  <= busy_next_s;
      if (pop_s) begin
        tick_cnt_r <= TICK_ZERO;
        bit_idx_r  <= BIT_ZERO;
      end else if (tick_end_s) begin
        tick_cnt_r <= TICK_ZERO;
        bit_idx_r  <= (state_next_s != state_r) ? BIT_ZERO : (bit_idx_r + BIT_ONE);
      end else if (tick_in && (state_r != ST_IDLE)) begin
        tick_cnt_r <= tick_cnt_r + TICK_ONE;
      end
    end
  end

  assign ready_out = ready_r;
  assign tx_out    = tx_r;
  assign busy_out  = busy_r;
  assign count_out = count_r;

endmodule

// File: tb/tb_uart_tx_framed.sv
// Directed bench for uart_tx_framed: four frame formats, FIFO back-pressure,
// asynchronous reset mid-frame and tick stall. Tick every 4 clocks, 64 clocks per bit.
module tb_uart_tx_framed;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       tick_en = 1'b1;
  logic       valid_drv = 1'b0;
  logic [7:0] data_drv = 8'h00;
  logic [1:0] sel = 2'd0;

  logic [3:0] valid_w;
  logic       tx_w    [4];
  logic       busy_w  [4];
  logic       ready_w [4];
  logic [2:0] count_w [4];
  logic       tx_sel, busy_sel, ready_sel;
  logic [2:0] count_sel;

  int cyc = 0;
  int tick_total = 0;
  int n_cmp = 0;
  int n_bad = 0;

  assign valid_w   = valid_drv ? (4'b0001 << sel) : 4'b0000;
  assign tx_sel    = tx_w[sel];
  assign busy_sel  = busy_w[sel];
  assign ready_sel = ready_w[sel];
  assign count_sel = count_w[sel];

  uart_tx_framed #(.SAMPLE_RATE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk_in(clk), .rst_n_in(rst_n), .tick_in(tick), .data_in(data_drv), .valid_in(valid_w[0]),
    .ready_out(ready_w[0]), .tx_out(tx_w[0]), .busy_out(busy_w[0]), .count_out(count_w[0]));
  uart_tx_framed #(.SAMPLE_RATE(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .clk_in(clk), .rst_n_in(rst_n), .tick_in(tick), .data_in(data_drv), .valid_in(valid_w[1]),
    .ready_out(ready_w[1]), .tx_out(tx_w[1]), .busy_out(busy_w[1]), .count_out(count_w[1]));
  uart_tx_framed #(.SAMPLE_RATE(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
    .clk_in(clk), .rst_n_in(rst_n), .tick_in(tick), .data_in(data_drv), .valid_in(valid_w[2]),
    .ready_out(ready_w[2]), .tx_out(tx_w[2]), .busy_out(busy_w[2]), .count_out(count_w[2]));
  uart_tx_framed #(.SAMPLE_RATE(16), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
    .clk_in(clk), .rst_n_in(rst_n), .tick_in(tick), .data_in(data_drv[6:0]), .valid_in(valid_w[3]),
    .ready_out(ready_w[3]), .tx_out(tx_w[3]), .busy_out(busy_w[3]), .count_out(count_w[3]));

  initial forever #5 clk = ~clk;

  // Tick strobe every 4th clock, frozen while tick_en is low.
  initial begin
    int div;
    div = 0;
    forever begin
      @(posedge clk);
      #2;
      if (tick_en) begin
        div  = (div + 1) % 4;
        tick = (div == 3);
      end else begin
        tick = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tick) tick_total <= tick_total + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time %0t, required finish before 1000000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int got, input int lo, input int hi);
    n_cmp++;
    if (got < lo || got > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic push(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    data_drv  = d;
    valid_drv = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (ready_sel === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_%0h: ready stayed %b, expected 1", d, ready_sel);
      valid_drv = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      valid_drv = 1'b0;
    end
  endtask

  // Waits for a start bit, then samples the middle of each bit by counting ticks.
  task automatic capture(input int nbits, output logic [63:0] bits, output int start_cyc);
    int  t0;
    int  w;
    bit  seen;
    seen      = 1'b0;
    bits      = 64'h0;
    start_cyc = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (tx_sel === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL capture_start: tx stayed %b, expected a 0 start bit", tx_sel);
    end else begin
      start_cyc = cyc;
      t0        = tick_total;
      for (int k = 0; k < nbits; k++) begin
        w = 0;
        while (tick_total < t0 + 16 * k + 8 && w < 3000) begin
          @(negedge clk);
          w++;
        end
        if (tick_total < t0 + 16 * k + 8) begin
          n_cmp++;
          n_bad++;
          $display("FAIL capture_tick: bit %0d got %0d ticks, expected %0d", k, tick_total - t0, 16 * k + 8);
          break;
        end
        bits[k] = tx_sel;
      end
    end
  endtask

  task automatic wait_idle(input string name, input int budget, output int end_cyc);
    for (int i = 0; i < budget; i++) begin
      if (busy_sel === 1'b0) break;
      @(negedge clk);
    end
    if (busy_sel !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_idle: busy got %b, expected 0 within %0d cycles", name, busy_sel, budget);
    end
    end_cyc = cyc;
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [7:0]  d0;
    logic [7:0]  d1;
    int          nfr;
    int          nbits;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [63:0] got;
    int          sc, ec, c0, bad_cyc, t0;
    bit          seen;

    vecs[0] = '{2'd0, 8'h93, 8'h00, 1, 10, {54'h0, 10'h326}, "8n1_93"};
    vecs[1] = '{2'd1, 8'hC3, 8'h00, 1, 11, {53'h0, 11'h586}, "even_c3"};
    vecs[2] = '{2'd1, 8'h93, 8'h00, 1, 11, {53'h0, 11'h526}, "even_93"};
    vecs[3] = '{2'd2, 8'hC3, 8'h00, 1, 11, {53'h0, 11'h786}, "odd_c3"};
    vecs[4] = '{2'd2, 8'h93, 8'h00, 1, 11, {53'h0, 11'h726}, "odd_93"};
    vecs[5] = '{2'd3, 8'h55, 8'h2A, 2, 20, {44'h0, 10'h354, 10'h3AA}, "7n2_55_2a"};
    vecs[6] = '{2'd1, 8'hC3, 8'h93, 2, 22, {42'h0, 11'h526, 11'h586}, "even_b2b"};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 64'(tx_sel), 64'h1);
    chk("rst_busy", 64'(busy_sel), 64'h0);
    chk("rst_ready", 64'(ready_sel), 64'h1);
    chk("rst_count", 64'(count_sel), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Frame formats
    for (int v = 0; v < 7; v++) begin
      sel = vecs[v].sel;
      fork
        capture(vecs[v].nbits, got, sc);
        begin
          push(vecs[v].d0);
          if (vecs[v].nfr == 2) push(vecs[v].d1);
        end
      join
      chk({vecs[v].name, "_bits"}, got, vecs[v].exp);
      wait_idle(vecs[v].name, 500, ec);
      chk_rng({vecs[v].name, "_len"}, ec - sc, vecs[v].nbits * 64 - 4, vecs[v].nbits * 64 + 4);
      chk({vecs[v].name, "_count"}, 64'(count_sel), 64'h0);
      chk({vecs[v].name, "_ready"}, 64'(ready_sel), 64'h1);
      repeat (10) @(negedge clk);
    end

    // FIFO fill and back-pressure with six contiguous frames
    sel = 2'd0;
    fork
      capture(60, got, sc);
      begin
        push(8'h01);
        push(8'h02);
        chk("fifo_pushpop_count", 64'(count_sel), 64'h1);
        push(8'h03);
        push(8'h04);
        push(8'h05);
        chk("fifo_full_count", 64'(count_sel), 64'h4);
        chk("fifo_full_ready", 64'(ready_sel), 64'h0);
        c0 = cyc;
        push(8'h06);
        chk_rng("fifo_stall_cycles", cyc - c0, 600, 680);
        chk("fifo_refill_count", 64'(count_sel), 64'h4);
      end
    join
    chk("fifo_six_frames", got, {4'h0, 10'h20C, 10'h20A, 10'h208, 10'h206, 10'h204, 10'h202});
    wait_idle("fifo", 500, ec);
    chk_rng("fifo_len", ec - sc, 60 * 64 - 4, 60 * 64 + 4);
    chk("fifo_end_count", 64'(count_sel), 64'h0);
    repeat (10) @(negedge clk);

    // Asynchronous reset during data bit 3 of 0xA5
    seen = 1'b0;
    fork
      begin
        for (int i = 0; i < 2000; i++) begin
          @(negedge clk);
          if (tx_sel === 1'b0) begin
            seen = 1'b1;
            break;
          end
        end
        t0 = tick_total;
        for (int i = 0; i < 2000; i++) begin
          if (tick_total >= t0 + 72) break;
          @(negedge clk);
        end
      end
      begin
        push(8'hA5);
        push(8'h11);
        push(8'h22);
      end
    join
    chk("rst_mid_start_seen", 64'(seen), 64'h1);
    chk("rst_mid_bit3", 64'(tx_sel), 64'h0);
    chk("rst_mid_queued", 64'(count_sel), 64'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tx", 64'(tx_sel), 64'h1);
    chk("rst_mid_busy", 64'(busy_sel), 64'h0);
    chk("rst_mid_count", 64'(count_sel), 64'h0);
    chk("rst_mid_ready", 64'(ready_sel), 64'h1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad_cyc = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx_sel !== 1'b1 || busy_sel !== 1'b0) bad_cyc++;
    end
    chk("rst_after_idle", 64'(bad_cyc), 64'h0);

    // Tick stall during the start bit, FIFO filled meanwhile
    seen = 1'b0;
    fork
      capture(50, got, sc);
      begin
        push(8'h93);
        for (int i = 0; i < 200; i++) begin
          if (tx_sel === 1'b0) begin
            seen = 1'b1;
            break;
          end
          @(negedge clk);
        end
        tick_en = 1'b0;
        bad_cyc = 0;
        repeat (300) begin
          @(negedge clk);
          if (tx_sel !== 1'b0 || busy_sel !== 1'b1) bad_cyc++;
        end
        chk("stall_hold", 64'(bad_cyc), 64'h0);
        push(8'h10);
        push(8'h20);
        push(8'h30);
        push(8'h40);
        chk("stall_full_count", 64'(count_sel), 64'h4);
        chk("stall_full_ready", 64'(ready_sel), 64'h0);
        repeat (50) @(negedge clk);
        tick_en = 1'b1;
      end
    join
    chk("stall_start_seen", 64'(seen), 64'h1);
    chk("stall_frames", got, {14'h0, 10'h280, 10'h260, 10'h240, 10'h220, 10'h326});
    wait_idle("stall", 1000, ec);
    chk("stall_end_count", 64'(count_sel), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_framed.md
Name: uart_tx_framed

Overview:
- Next-generation UART transmitter with a configurable frame format: 5–9 data bits, none/odd/even parity, and 1 or 2 stop bits.
- Includes a small input FIFO with a valid/ready handshake, so producers can queue several characters while a frame is on the line.
- Bit timing comes from the existing uart_tick_generator: SAMPLE_RATE ticks make one bit period.
- Sits between the command/datapath logic and the board TX pin.

Parameters:
- SAMPLE_RATE, 16: tick_in pulses per bit period (≥2).
- DATA_BITS, 8: data bits per frame (5–9), sent LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2 stop bits.
- FIFO_DEPTH, 4: queued characters; power of two, ≥2.

Ports:
- clk_in  input  1  system clock (100 MHz).
- rst_n_in  input  1  reset. One clock; reset is asynchronous and active-low.
- tick_in  input  1  one-cycle oversample strobe from uart_tick_generator.
- data_in  input  DATA_BITS  character to queue.
- valid_in  input  1  data_in valid; push occurs when valid_in && ready_out at a rising edge.
- ready_out  output  1  FIFO not full.
- tx_out  output  1  serial line, idle high.
- busy_out  output  1  frame in progress or FIFO non-empty.
- count_out  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - tx_out=1, busy_out=0, ready_out=1, count_out=0.
  - FSM goes to IDLE; FIFO is flushed; tick and bit counters are cleared.
- Reset mid-frame aborts the frame; the line returns high at once.
- FIFO:
  - Push when valid_in && ready_out. ready_out = (count_out != FIFO_DEPTH) and is registered from occupancy.
  - A push while full is not accepted, even in a cycle where a pop occurs.
  - Simultaneous push and pop when not full leaves count_out unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE:
    - tx_out=1.
    - If the FIFO is non-empty: pop the head into the shift register, clear the tick counter, go to START.
    - tx_out goes low on the clock after the pop (1-cycle latency).
  - Bit duration: every bit state holds tx_out for exactly SAMPLE_RATE tick_in pulses.
    - The tick counter increments on tick_in.
    - The state advances on the tick_in where tick counter == SAMPLE_RATE-1; the counter then resets to 0.
    - No tick_in means no advance.
  - START: tx_out=0, then go to DATA with bit index 0.
  - DATA:
    - tx_out = shift[0]; shift right after each bit.
    - After DATA_BITS bits, go to PARITY if PARITY != 0, else STOP.
  - PARITY:
    - Even: tx_out = XOR of all data bits.
    - Odd: tx_out = inverted XOR of all data bits.
    - Parity is computed from the data latched at pop.
  - STOP:
    - tx_out=1 for STOP_BITS bit periods.
    - At the end, if the FIFO is non-empty, pop and go directly to START on the same edge. Back-to-back frames have no idle gap.
    - Otherwise go to IDLE.
- busy_out = (state != IDLE) || (count_out != 0). It is high on the cycle after the first push. It falls on the cycle after the last stop bit completes with the FIFO empty.
- data_in is sampled only at push; later changes do not affect queued or in-flight frames.
- Frame length in bits = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS.
- tx_out is driven directly from a register (glitch-free).

Test Plan:
- All scenarios drive tick_in every 4 clocks, so one bit = 64 clocks.
1. Defaults (8N1). Push 0x93 -> tx_out sequence 0,1,1,0,0,1,0,0,1,1, each bit 16 ticks. busy_out falls 640 clocks (±4) after the start bit begins. count_out returns to 0.
2. PARITY=2. Push 0xC3 -> parity bit 0; push 0x93 -> parity bit 0. With PARITY=1, the same bytes give parity 1 and 1. Frame length is 11 bits.
3. DATA_BITS=7, STOP_BITS=2. Push 0x55 -> bits 0,1,0,1,0,1,0,1,1,1, total 10 bits (160 ticks). The next queued frame starts immediately after the second stop bit.
4. FIFO_DEPTH=4. Push 0x01..0x06 on consecutive cycles with valid_in held high:
   - 0x01 is popped immediately; 0x02–0x05 fill the FIFO (count_out=4, ready_out=0).
   - 0x06 is stalled until the first pop after frame 0x01 ends.
   - The line shows six contiguous frames with no idle high beyond the stop bits, in order 0x01..0x06.
5. Reset mid-frame: drop rst_n_in during data bit 3 of 0xA5 with 2 bytes queued -> tx_out=1, busy_out=0, count_out=0, ready_out=1 without a clock edge. After release, the line stays high until a new push.
6. Tick stall: stop tick_in during the START bit -> tx_out remains 0 and busy_out remains 1. Pushes continue up to full. Resuming ticks completes the frame with correct bit widths.
